// File: rtl/div_arbiter.sv
// div_arbiter: round-robin arbiter sharing one iterative divider between EX (0) and an auxiliary requester (1),
// with flush, watchdog timeout and a re-arm mask against stale held requests.
module div_arbiter #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_i,
  input  logic [1:0]            signed_i,
  input  logic [2*DATA_W-1:0]   op1_i,
  input  logic [2*DATA_W-1:0]   op2_i,
  input  logic [1:0]            flush_i,
  output logic [1:0]            grant_o,
  output logic [1:0]            done_o,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  timeout_o,
  output logic                  div_start_o,
  output logic                  div_cancel_o,
  output logic                  div_signed_o,
  output logic [DATA_W-1:0]     div_data1_o,
  output logic [DATA_W-1:0]     div_data2_o,
  input  logic [2*DATA_W-1:0]   div_result_i,
  input  logic                  div_done_i
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t              state_q, state_d;
  logic [1:0]          grant_q, grant_d, done_q, done_d, rearm_q, rearm_d, elig;
  logic                last_q, last_d, pick, cancel, tmo;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*DATA_W-1:0] res_q, res_d;
  logic                sgn_q, sgn_d;
  logic [DATA_W-1:0]   d1_q, d1_d, d2_q, d2_d;
  assign elig = req_i & ~flush_i & ~rearm_q;
  // on a tie the requester that did not win last time goes next
  assign pick = (elig == 2'b11) ? ~last_q : elig[1];
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    last_d  = last_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    sgn_d   = sgn_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    cancel  = 1'b0;
    tmo     = 1'b0;
    rearm_d = rearm_q & req_i;
    case (state_q)
      IDLE: if (|elig) begin
        grant_d = pick ? 2'b10 : 2'b01;
        last_d  = pick;
        cnt_d   = '0;
        sgn_d   = signed_i[pick];
        d1_d    = pick ? op1_i[2*DATA_W-1:DATA_W] : op1_i[DATA_W-1:0];
        d2_d    = pick ? op2_i[2*DATA_W-1:DATA_W] : op2_i[DATA_W-1:0];
        state_d = BUSY;
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (|(flush_i & grant_q)) begin
          cancel  = 1'b1;
          grant_d = '0;
          state_d = IDLE;
        end else if (div_done_i) begin
          res_d   = div_result_i;
          done_d  = grant_q;
          rearm_d = rearm_d | grant_q;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          cancel  = 1'b1;
          tmo     = 1'b1;
          grant_d = '0;
          state_d = IDLE;
        end
      end
      DONE: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      rearm_q <= '0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      res_q   <= '0;
      sgn_q   <= 1'b0;
      d1_q    <= '0;
      d2_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      rearm_q <= rearm_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      sgn_q   <= sgn_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
    end
  end
  assign grant_o      = grant_q;
  assign done_o       = done_q;
  assign result_o     = res_q;
  assign timeout_o    = tmo;
  assign div_start_o  = state_q == BUSY;
  assign div_cancel_o = cancel;
  assign div_signed_o = sgn_q;
  assign div_data1_o  = d1_q;
  assign div_data2_o  = d2_q;
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed scenarios with a scoreboard of expected done/cancel/timeout events,
// plus a small divider model whose completion latency is set per scenario.
module tb_div_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_i = '0, signed_i = '0, flush_i = '0;
  logic [63:0] op1_i = '0, op2_i = '0;
  logic [1:0]  grant_o, done_o;
  logic [63:0] result_o, div_result_i;
  logic        timeout_o, div_start_o, div_cancel_o, div_signed_o, div_done_i;
  logic [31:0] div_data1_o, div_data2_o;
  div_arbiter #(.DATA_W(32), .TIMEOUT(40)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .signed_i(signed_i), .op1_i(op1_i), .op2_i(op2_i),
    .flush_i(flush_i), .grant_o(grant_o), .done_o(done_o), .result_o(result_o),
    .timeout_o(timeout_o), .div_start_o(div_start_o), .div_cancel_o(div_cancel_o),
    .div_signed_o(div_signed_o), .div_data1_o(div_data1_o), .div_data2_o(div_data2_o),
    .div_result_i(div_result_i), .div_done_i(div_done_i)
  );
  always #5 clk = ~clk;
  // divider model: done_i rises in BUSY cycle number lat (0 = never finishes)
  int         lat = 0;
  logic [7:0] dcnt = '0;
  logic       model_done = 1'b0, spur = 1'b0;
  always @(posedge clk) begin
    if (!div_start_o || div_cancel_o) begin
      dcnt       <= '0;
      model_done <= 1'b0;
    end else begin
      dcnt       <= dcnt + 8'd1;
      model_done <= (lat != 0) && (int'(dcnt) == lat - 1);
    end
  end
  assign div_done_i   = model_done | spur;
  assign div_result_i = {div_data1_o % div_data2_o, div_data1_o / div_data2_o};
  typedef struct packed {
    logic [1:0]  done;
    logic        cancel;
    logic        tmo;
    logic [63:0] res;
  } exp_t;
  exp_t exp_q[$];
  int   errors = 0, checks = 0;
  task automatic push(input logic [1:0] d, input logic c, input logic t, input logic [63:0] r);
    exp_t e;
    e.done = d; e.cancel = c; e.tmo = t; e.res = r;
    exp_q.push_back(e);
  endtask
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (rst && (done_o != 2'b00 || div_cancel_o || timeout_o)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got done=%b cancel=%b timeout=%b expected none", done_o, div_cancel_o, timeout_o);
      end else begin
        automatic exp_t e = exp_q.pop_front();
        if ({done_o, div_cancel_o, timeout_o} !== {e.done, e.cancel, e.tmo} || (e.done != 2'b00 && result_o !== e.res)) begin
          errors++;
          $display("FAIL event: got done=%b cancel=%b timeout=%b result=%h expected done=%b cancel=%b timeout=%b result=%h",
                   done_o, div_cancel_o, timeout_o, result_o, e.done, e.cancel, e.tmo, e.res);
        end
      end
    end
  end
  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_outputs", {grant_o, done_o, timeout_o, div_start_o, div_cancel_o, div_signed_o}, '0);
    chk("rst_data", {result_o, div_data1_o, div_data2_o}, '0);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
  endtask
  initial begin
    do_reset();
    // single op 100/7, divider latency 33: grant in cycle 1, done in cycle 35
    lat = 33; op1_i = {32'd0, 32'd100}; op2_i = {32'd0, 32'd7}; req_i = 2'b01;
    step(1);
    chk("single_grant", grant_o, 2'b01);
    chk("single_start", div_start_o, 1'b1);
    chk("single_ops", {div_data1_o, div_data2_o}, {32'd100, 32'd7});
    push(2'b01, 1'b0, 1'b0, {32'd2, 32'd14});
    op1_i = {32'd0, 32'd999};
    step(34);
    chk("single_done", done_o, 2'b01);
    chk("single_result", result_o, {32'd2, 32'd14});
    chk("single_start_low", div_start_o, 1'b0);
    req_i = 2'b00;
    step(2);
    // tie from reset: requester 0 first, then requester 1 with its own operands
    do_reset();
    lat = 5; op1_i = {32'd91, 32'd50}; op2_i = {32'd10, 32'd6}; req_i = 2'b11;
    step(1);
    chk("tie_grant0", grant_o, 2'b01);
    chk("tie_ops0", div_data1_o, 32'd50);
    push(2'b01, 1'b0, 1'b0, {32'd2, 32'd8});
    flush_i = 2'b10;
    step(1);
    flush_i = 2'b00;
    step(5);
    chk("tie_done0", done_o, 2'b01);
    req_i = 2'b10;
    step(1);
    chk("tie_gap", {grant_o, div_start_o}, 3'b000);
    step(1);
    chk("tie_grant1", grant_o, 2'b10);
    chk("tie_ops1", {div_data1_o, div_data2_o}, {32'd91, 32'd10});
    push(2'b10, 1'b0, 1'b0, {32'd1, 32'd9});
    step(6);
    chk("tie_done1", done_o, 2'b10);
    req_i = 2'b00;
    step(2);
    // stale request held after done must not re-issue
    lat = 3; op1_i = {32'd0, 32'd100}; op2_i = {32'd0, 32'd7}; req_i = 2'b01;
    step(1);
    push(2'b01, 1'b0, 1'b0, {32'd2, 32'd14});
    step(4);
    chk("stale_done", done_o, 2'b01);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("stale_no_grant", {grant_o, div_start_o}, 3'b000);
    end
    req_i = 2'b00;
    step(1);
    op1_i = {32'd0, 32'd81}; op2_i = {32'd0, 32'd9}; signed_i = 2'b01; req_i = 2'b01;
    step(1);
    chk("stale_regrant", grant_o, 2'b01);
    chk("stale_signed", div_signed_o, 1'b1);
    push(2'b01, 1'b0, 1'b0, {32'd0, 32'd9});
    step(4);
    chk("stale_done2", done_o, 2'b01);
    req_i = 2'b00; signed_i = 2'b00;
    step(2);
    // spurious divider done in IDLE is ignored
    spur = 1'b1;
    step(1);
    spur = 1'b0;
    step(1);
    chk("spur_ignored", {done_o, grant_o}, 4'b0000);
    // flush in flight at BUSY cycle 10, same cycle as div_done_i
    lat = 10; op1_i = {32'd0, 32'd100}; op2_i = {32'd0, 32'd7}; req_i = 2'b01;
    step(1);
    push(2'b00, 1'b1, 1'b0, '0);
    step(10);
    flush_i = 2'b01; req_i = 2'b00;
    #1;
    chk("flush_cancel", div_cancel_o, 1'b1);
    step(1);
    flush_i = 2'b00;
    chk("flush_idle", {grant_o, done_o, div_start_o, div_cancel_o}, 6'b0);
    step(2);
    // watchdog: divider never finishes
    lat = 0; req_i = 2'b01;
    step(1);
    push(2'b00, 1'b1, 1'b1, '0);
    step(39);
    chk("tmo_pulse", {timeout_o, div_cancel_o}, 2'b11);
    step(1);
    chk("tmo_idle", {grant_o, div_start_o, timeout_o}, 4'b0000);
    step(1);
    chk("tmo_regrant", grant_o, 2'b01);
    push(2'b00, 1'b1, 1'b0, '0);
    flush_i = 2'b01; req_i = 2'b00;
    step(1);
    flush_i = 2'b00;
    step(1);
    // async reset mid-BUSY
    op1_i = {32'd40, 32'd30}; op2_i = {32'd3, 32'd4}; req_i = 2'b11;
    step(1);
    chk("ar_grant_rr", grant_o, 2'b10);
    step(5);
    #2 rst = 1'b0;
    #1;
    chk("ar_immediate", {grant_o, done_o, div_start_o, div_cancel_o}, 6'b0);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    step(1);
    chk("ar_tie_req0", grant_o, 2'b01);
    push(2'b00, 1'b1, 1'b0, '0);
    flush_i = 2'b11; req_i = 2'b00;
    step(1);
    flush_i = 2'b00;
    step(3);
    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Sequences and shares the single iterative divider between two requesters: requester 0 is the EX stage and requester 1 is an auxiliary requester.
- Grants the divider round-robin, captures operands at grant and drives the divider start/cancel handshake.
- Routes the 2*DATA_W result back to the granted requester with a one-cycle done pulse.
- Handles pipeline flush and a watchdog timeout. Sits between the requesters and the divider; the divider's cancel input comes from here.

Parameters:
- DATA_W, 32, operand width; result width is 2*DATA_W.
- TIMEOUT, 40, max cycles in BUSY before forced cancel.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_i  in  2  per-requester level request; held high until that requester's done_o.
- signed_i  in  2  per-requester signed-division flag.
- op1_i  in  2*DATA_W  dividends, packed; [DATA_W-1:0] is requester 0.
- op2_i  in  2*DATA_W  divisors, packed as op1_i.
- flush_i  in  2  per-requester flush; kills a pending or in-flight request.
- grant_o  out  2  one-hot, registered; the current owner; high in BUSY and DONE.
- done_o  out  2  one-cycle pulse to the owner when its result is valid.
- result_o  out  2*DATA_W  registered result, valid while done_o != 0.
- timeout_o  out  1  one-cycle pulse on watchdog expiry.
- div_start_o  out  1  level start to the divider; high only in BUSY.
- div_cancel_o  out  1  one-cycle cancel pulse to the divider.
- div_signed_o  out  1  captured signed flag.
- div_data1_o  out  DATA_W  captured dividend.
- div_data2_o  out  DATA_W  captured divisor.
- div_result_i  in  2*DATA_W  divider result.
- div_done_i  in  1  divider done; sampled only in BUSY.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all outputs 0; last_grant=1, so requester 0 wins the first tie.
  - rearm mask = 00; cycle counter = 0.
  - Reset mid-operation aborts silently: no done_o and no cancel pulse.
- Eligibility: eligible[n] = req_i[n] & ~flush_i[n] & ~rearm[n].
- rearm[n]:
  - Set when done_o[n] fires.
  - Cleared once req_i[n] is sampled low.
  - Prevents a stale held request from re-issuing the same division.
- IDLE:
  - No eligible requester: stay in IDLE.
  - Exactly one eligible: grant it.
  - Both eligible: grant the requester that is not last_grant.
  - On grant (registered):
    - Set grant_o; capture signed_i, op1_i and op2_i slices into the div_* outputs.
    - Set last_grant; counter = 0; state -> BUSY.
  - div_start_o rises the cycle after req_i is first sampled.
- BUSY:
  - div_start_o = 1; counter increments each cycle.
  - Operands stay frozen even if the requester's inputs change.
  - flush_i[owner] = 1 (priority 1):
    - div_cancel_o pulses; grant_o = 0; state -> IDLE.
    - No done_o, even if div_done_i is high the same cycle.
  - Otherwise div_done_i = 1 (priority 2):
    - result_o <= div_result_i; done_o[owner] pulses next cycle; state -> DONE.
  - Otherwise counter == TIMEOUT-1 (priority 3):
    - div_cancel_o and timeout_o pulse; grant_o = 0; state -> IDLE.
    - No done_o; the requester's req stays pending and is re-arbitrated.
- DONE, exactly 1 cycle:
  - done_o[owner] = 1; div_start_o = 0; result_o valid.
  - Next state IDLE; grant_o cleared at exit.
  - result_o holds its value until the next done.
- Other rules:
  - flush_i of the non-owner has no effect on the in-flight op.
  - div_done_i outside BUSY is ignored.
  - Minimum request-to-done latency: divider latency + 2 cycles.
  - Back-to-back gap: at least 1 IDLE cycle with div_start_o low between ops.
- result_o is not modified by the arbiter; signedness is handled in the divider.

Test Plan:
- Single op: req_i=01, op1=100, op2=7, signed=0; divider done after 33 cycles -> grant_o=01 at cycle 1; done_o=01 pulse at cycle 35; result_o carries quotient 14, remainder 2 exactly as the divider's div_result_i; div_start_o low at cycle 35.
- Tie: req_i=11 from reset -> requester 0 served first, done_o=01; after IDLE, requester 1 is granted with its own operands; both done_o pulses occur and are distinct.
- Stale request: requester 0 holds req high for 3 cycles after done_o -> no second grant to it until req is sampled low; a new request after the low cycle is granted.
- Flush in flight: flush_i=01 at BUSY cycle 10, same cycle as div_done_i -> div_cancel_o one pulse, no done_o, state back to IDLE next cycle.
- Timeout: divider never asserts done, TIMEOUT=40 -> at BUSY cycle 39, timeout_o and div_cancel_o pulse once; requester re-granted after one IDLE cycle.
- Async reset mid-BUSY: rst low between clock edges -> grant_o, div_start_o, done_o = 0 immediately; no cancel pulse; after release, requester 0 wins a tie.
